// File: rtl/decode_inst_queue_pkg.sv
// Shared constants for the decode instruction queue: MIPS branch/jump
// opcode and funct encodings plus the fetch-exception flag layout.
package decode_inst_queue_pkg;

  // Fetch exception flag vector {inst_miss, inst_illegal, inst_invalid}
  localparam int EXC_W       = 3;
  localparam int EXC_MISS    = 2;
  localparam int EXC_ILLEGAL = 1;
  localparam int EXC_INVALID = 0;

  typedef logic [EXC_W-1:0] exc_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // REGIMM rt codes (instr[20:16])
  localparam logic [4:0] RT_BLTZ   = 5'h00;
  localparam logic [4:0] RT_BGEZ   = 5'h01;
  localparam logic [4:0] RT_BLTZAL = 5'h10;
  localparam logic [4:0] RT_BGEZAL = 5'h11;

endpackage

// File: rtl/decode_inst_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// The slave modport is the queue itself; master is the surrounding pipeline.
interface decode_inst_queue_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  import decode_inst_queue_pkg::*;

  // Fetch side
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  exc_t               in_exc;
  logic               in_afull;

  // Decode side
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  exc_t               out_exc;
  logic               out_in_delayslot;
  logic [PC_W-1:0]    out_epc;

  modport master (
    output in_valid, in_pc, in_instr, in_exc, out_ready,
    input  in_ready, in_afull, out_valid, out_pc, out_instr, out_exc,
           out_in_delayslot, out_epc
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_exc, out_ready,
    output in_ready, in_afull, out_valid, out_pc, out_instr, out_exc,
           out_in_delayslot, out_epc
  );

endinterface

// File: rtl/decode_inst_queue_branch_predecode.sv
// Pure combinational predecode: flags any MIPS branch or jump, i.e. any
// instruction that is followed by an architectural delay slot.
module branch_predecode
  import decode_inst_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_branch
);

  logic [5:0] opcode;
  logic [4:0] rt;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign rt            = instr[20:16];
  assign funct         = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  // Decode opcode, then REGIMM rt / SPECIAL funct sub-fields
  always_comb begin
    is_branch = 1'b0;
    case (opcode)
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
      OP_REGIMM:
        is_branch = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                    (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
      OP_SPECIAL:
        is_branch = (funct == FN_JR) || (funct == FN_JALR);
      default: is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_inst_queue.sv
// Instruction buffer between fetch and the decode pipeline register.
// Holds PC, instruction word and fetch exception flags per entry, tracks
// whether the head sits in a branch delay slot and produces its EPC.
module decode_inst_queue
  import decode_inst_queue_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_W     = 32,
  parameter int INSTR_W  = 32,
  parameter int AFULL_TH = 3
) (
  input  logic                     Clk,
  input  logic                     Resetn,
  input  logic                     exp_flush,
  decode_inst_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage (not reset: occupancy alone decides what is valid)
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  exc_t               exc_mem_q   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ds_flag_q, ds_flag_d;

  logic               empty, full, push, pop, head_is_branch;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;
  exc_t               head_exc;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign push  = bus.in_valid & ~full;
  assign pop   = ~empty & bus.out_ready;

  // Head fields read straight from storage, forced to zero when empty
  always_comb begin
    head_pc    = '0;
    head_instr = '0;
    head_exc   = '0;
    if (!empty) begin
      head_pc    = pc_mem_q[rd_ptr_q];
      head_instr = instr_mem_q[rd_ptr_q];
      head_exc   = exc_mem_q[rd_ptr_q];
    end
  end

  branch_predecode u_predecode (
    .instr     (head_instr[31:0]),
    .is_branch (head_is_branch)
  );

  // Pointer, occupancy and delay-slot next state; flush overrides everything
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ds_flag_d = ds_flag_q;
    if (exp_flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      ds_flag_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        ds_flag_d = head_is_branch;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ds_flag_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ds_flag_q <= ds_flag_d;
    end
  end

  // Entry write; a push coinciding with a flush is dropped
  always_ff @(posedge Clk) begin
    if (push && !exp_flush) begin
      pc_mem_q[wr_ptr_q]    <= bus.in_pc;
      instr_mem_q[wr_ptr_q] <= bus.in_instr;
      exc_mem_q[wr_ptr_q]   <= bus.in_exc;
    end
  end

  assign bus.in_ready         = ~full;
  assign bus.in_afull         = (count_q >= CNT_W'(AFULL_TH));
  assign bus.out_valid        = ~empty;
  assign bus.out_pc           = head_pc;
  assign bus.out_instr        = head_instr;
  assign bus.out_exc          = head_exc;
  assign bus.out_in_delayslot = ds_flag_q & ~empty;
  assign bus.out_epc          = (ds_flag_q & ~empty) ? head_pc - PC_W'(4) : head_pc;
  assign count                = count_q;

endmodule

// File: tb/tb_decode_inst_queue.sv
// Directed self-checking bench for decode_inst_queue (DEPTH=4, AFULL_TH=3).
module tb_decode_inst_queue;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADDIU = 32'h2401_0000;
  localparam logic [31:0] BEQ   = 32'h1000_0000;
  localparam logic [31:0] JAL   = 32'h0C00_0000;

  logic       Clk;
  logic       Resetn;
  logic       exp_flush;
  logic [2:0] count;

  int assertCount;
  int failCount;

  decode_inst_queue_if #(.PC_W(32), .INSTR_W(32)) dqIf ();

  decode_inst_queue #(
    .DEPTH(4), .PC_W(32), .INSTR_W(32), .AFULL_TH(3)
  ) dut (
    .Clk       (Clk),
    .Resetn    (Resetn),
    .exp_flush (exp_flush),
    .bus       (dqIf.slave),
    .count     (count)
  );

  // Free-running clock, 10 time-unit period
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle 1 unit past the rising edge
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [2:0] exc, input logic rdy, input logic flush);
    dqIf.in_valid  = v;
    dqIf.in_pc     = pc;
    dqIf.in_instr  = instr;
    dqIf.in_exc    = exc;
    dqIf.out_ready = rdy;
    exp_flush      = flush;
    @(posedge Clk);
    #1;
  endtask

  // Directed scenario sequence
  initial begin
    int expCnt;
    assertCount = 0;
    failCount   = 0;
    Resetn = 1'b0;

    // Reset held with a push offered
    applyStimulus(1'b1, 32'hDEAD_0000, ADDIU, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_0004, ADDIU, 3'b000, 1'b0, 1'b0);
    checkOutput("rst_out_valid", 64'(dqIf.out_valid), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_in_ready", 64'(dqIf.in_ready), 64'd1);
    checkOutput("rst_in_afull", 64'(dqIf.in_afull), 64'd0);
    checkOutput("rst_out_pc_gated", 64'(dqIf.out_pc), 64'd0);
    Resetn = 1'b1;

    // First entry after reset
    applyStimulus(1'b1, 32'hBFC0_0000, NOP, 3'b000, 1'b0, 1'b0);
    checkOutput("boot_out_valid", 64'(dqIf.out_valid), 64'd1);
    checkOutput("boot_out_pc", 64'(dqIf.out_pc), 64'hBFC0_0000);
    checkOutput("boot_out_epc", 64'(dqIf.out_epc), 64'hBFC0_0000);
    checkOutput("boot_ds", 64'(dqIf.out_in_delayslot), 64'd0);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);
    checkOutput("boot_pop_count", 64'(count), 64'd0);

    // Fill to full, fifth push refused
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'(i * 4), ADDIU | 32'(i), 3'b000, 1'b0, 1'b0);
      expCnt = (i < 4) ? i + 1 : 4;
      checkOutput($sformatf("fill_count_%0d", i), 64'(count), 64'(expCnt));
      checkOutput($sformatf("fill_afull_%0d", i), 64'(dqIf.in_afull), 64'(expCnt >= 3));
      checkOutput($sformatf("fill_in_ready_%0d", i), 64'(dqIf.in_ready), 64'(expCnt < 4));
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_pc_%0d", i), 64'(dqIf.out_pc), 64'(i * 4));
      checkOutput($sformatf("drain_instr_%0d", i), 64'(dqIf.out_instr), 64'(ADDIU | 32'(i)));
      applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 64'(dqIf.out_valid), 64'd0);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);
    checkOutput("empty_pop_count", 64'(count), 64'd0);

    // Branch followed directly by its delay slot
    applyStimulus(1'b1, 32'h100, BEQ, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h104, NOP, 3'b000, 1'b0, 1'b0);
    checkOutput("beq_head_ds", 64'(dqIf.out_in_delayslot), 64'd0);
    checkOutput("beq_head_epc", 64'(dqIf.out_epc), 64'h100);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);
    checkOutput("slot_pc", 64'(dqIf.out_pc), 64'h104);
    checkOutput("slot_ds", 64'(dqIf.out_in_delayslot), 64'd1);
    checkOutput("slot_epc", 64'(dqIf.out_epc), 64'h100);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);

    // Branch, three empty cycles, then the delay slot arrives
    applyStimulus(1'b1, 32'h200, BEQ, 3'b000, 1'b0, 1'b0);
    checkOutput("bub_beq_ds", 64'(dqIf.out_in_delayslot), 64'd0);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);
    checkOutput("bub_empty_ds_gated", 64'(dqIf.out_in_delayslot), 64'd0);
    applyStimulus(1'b1, 32'h204, NOP, 3'b000, 1'b0, 1'b0);
    checkOutput("bub_slot_ds", 64'(dqIf.out_in_delayslot), 64'd1);
    checkOutput("bub_slot_epc", 64'(dqIf.out_epc), 64'h200);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);

    // Steady simultaneous push/pop at count 2, pointers wrap
    applyStimulus(1'b1, 32'h300, ADDIU, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, ADDIU, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("pp_pc_%0d", k), 64'(dqIf.out_pc), 64'(32'h300 + 32'(4 * k)));
      checkOutput($sformatf("pp_count_%0d", k), 64'(count), 64'd2);
      applyStimulus(1'b1, 32'h308 + 32'(4 * k), ADDIU, 3'b000, 1'b1, 1'b0);
    end
    checkOutput("pp_final_count", 64'(count), 64'd2);
    checkOutput("pp_tail0", 64'(dqIf.out_pc), 64'h328);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);
    checkOutput("pp_tail1", 64'(dqIf.out_pc), 64'h32C);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);

    // Flush after popping a jal, with a concurrent push
    applyStimulus(1'b1, 32'h400, JAL, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h404, NOP, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h408, NOP, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40C, NOP, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);
    checkOutput("jal_count", 64'(count), 64'd3);
    checkOutput("jal_slot_ds", 64'(dqIf.out_in_delayslot), 64'd1);
    checkOutput("jal_slot_epc", 64'(dqIf.out_epc), 64'h400);
    checkOutput("flush_in_ready", 64'(dqIf.in_ready), 64'd1);
    applyStimulus(1'b1, 32'h500, NOP, 3'b000, 1'b0, 1'b1);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_out_valid", 64'(dqIf.out_valid), 64'd0);
    applyStimulus(1'b1, 32'h600, NOP, 3'b000, 1'b0, 1'b0);
    checkOutput("post_flush_pc", 64'(dqIf.out_pc), 64'h600);
    checkOutput("post_flush_ds", 64'(dqIf.out_in_delayslot), 64'd0);
    checkOutput("post_flush_epc", 64'(dqIf.out_epc), 64'h600);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);

    // Exception flags, then asynchronous reset mid-stream
    applyStimulus(1'b1, 32'h700, NOP, 3'b100, 1'b0, 1'b0);
    checkOutput("exc_head", 64'(dqIf.out_exc), 64'h4);
    applyStimulus(1'b1, 32'h704, NOP, 3'b001, 1'b0, 1'b0);
    checkOutput("exc_count", 64'(count), 64'd2);
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b0, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 64'(dqIf.out_valid), 64'd0);
    checkOutput("async_rst_count", 64'(count), 64'd0);
    checkOutput("async_rst_out_exc", 64'(dqIf.out_exc), 64'd0);
    @(posedge Clk);
    #1;
    Resetn = 1'b1;
    applyStimulus(1'b0, 32'h0, NOP, 3'b000, 1'b1, 1'b0);
    checkOutput("after_rst_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
